// File: rtl/square_root_floor.sv
// Sequential floor square root of a 10-bit operand, one result every 7 cycles.
// Define SQRT_REMAINDER_EN to add the 6-bit remainder output rem.
module square_root_floor (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] num,
   output logic [4:0] sqrt,
`ifdef SQRT_REMAINDER_EN
   output logic [5:0] rem,
`endif
   output logic       done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [9:0]  op_q, op_d;
   logic [4:0]  root_q, root_d;
   logic [8:0]  part_q, part_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [4:0]  sqrt_q, sqrt_d;
   logic        done_q, done_d;

   logic [8:0]  shifted;
   logic [8:0]  trial;
   logic [8:0]  diff;
   logic        neg;

   // One restoring step: bring down the top operand pair, try subtracting 4*root+1.
   always_comb begin
      shifted = (part_q << 2) | {7'b0, op_q[9:8]};
      trial   = {2'b00, root_q, 2'b01};
      diff    = shifted - trial;
      neg     = (shifted < trial);
   end

`ifdef SQRT_REMAINDER_EN
   logic [5:0] rem_q, rem_d;
`endif

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      root_d  = root_q;
      part_d  = part_q;
      cnt_d   = cnt_q;
      sqrt_d  = sqrt_q;
      done_d  = 1'b0;
`ifdef SQRT_REMAINDER_EN
      rem_d   = rem_q;
`endif
      unique case (state_q)
         IDLE: begin
            op_d    = num;
            root_d  = '0;
            part_d  = '0;
            cnt_d   = 3'd4;
            state_d = CALC;
         end
         CALC: begin
            op_d = {op_q[7:0], 2'b00};
            if (neg) begin
               part_d = shifted;
               root_d = {root_q[3:0], 1'b0};
            end else begin
               part_d = diff;
               root_d = {root_q[3:0], 1'b1};
            end
            if (cnt_q == '0) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         DONE: begin
            sqrt_d  = root_q;
            done_d  = 1'b1;
`ifdef SQRT_REMAINDER_EN
            rem_d   = part_q[5:0];
`endif
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= '0;
         root_q  <= '0;
         part_q  <= '0;
         cnt_q   <= '0;
         sqrt_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         root_q  <= root_d;
         part_q  <= part_d;
         cnt_q   <= cnt_d;
         sqrt_q  <= sqrt_d;
         done_q  <= done_d;
      end
   end

`ifdef SQRT_REMAINDER_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q <= '0;
      end else begin
         rem_q <= rem_d;
      end
   end

   assign rem = rem_q;
`endif

   assign sqrt = sqrt_q;
   assign done = done_q;

endmodule

// File: tb/tb_square_root_floor.sv
// Scoreboard bench for square_root_floor: stimulus pushes expected roots,
// a negedge monitor pops and compares on every done pulse.
module tb_square_root_floor;

   logic       clk;
   logic       rst;
   logic [9:0] num;
   logic [4:0] sqrt;
   logic       done;
`ifdef SQRT_REMAINDER_EN
   logic [5:0] rem;
`endif

   square_root_floor dut (
      .clk  (clk),
      .rst  (rst),
      .num  (num),
      .sqrt (sqrt),
`ifdef SQRT_REMAINDER_EN
      .rem  (rem),
`endif
      .done (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int sq;
      int rm;
      int arg;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   held_sq = 0;
   int   held_rm = 0;
   bit   prev_done = 1'b0;

   function automatic int ref_sqrt(input int v);
      int r;
      r = 0;
      while ((r + 1) * (r + 1) <= v) r++;
      return r;
   endfunction

   task automatic push_exp(input int v);
      exp_t e;
      e.arg = v;
      e.sq  = ref_sqrt(v);
      e.rm  = v - e.sq * e.sq;
      sb.push_back(e);
   endtask

   // Monitor: compare on done, otherwise outputs must hold their last value.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         held_sq   = 0;
         held_rm   = 0;
         prev_done = 1'b0;
      end else if (done) begin
         checks++;
         if (prev_done) begin
            errors++;
            $display("FAIL done_width: done high on consecutive cycles, required single-cycle pulse");
         end
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: sqrt=%0d with empty scoreboard", sqrt);
         end else begin
            e = sb.pop_front();
            checks++;
            if (sqrt !== 5'(e.sq)) begin
               errors++;
               $display("FAIL sqrt(%0d): got %0d required %0d", e.arg, sqrt, e.sq);
            end
`ifdef SQRT_REMAINDER_EN
            checks++;
            if (rem !== 6'(e.rm)) begin
               errors++;
               $display("FAIL rem(%0d): got %0d required %0d", e.arg, rem, e.rm);
            end
`endif
            held_sq = e.sq;
            held_rm = e.rm;
         end
         prev_done = 1'b1;
      end else begin
         checks++;
         if (sqrt !== 5'(held_sq)) begin
            errors++;
            $display("FAIL sqrt_hold: got %0d required %0d", sqrt, held_sq);
         end
`ifdef SQRT_REMAINDER_EN
         checks++;
         if (rem !== 6'(held_rm)) begin
            errors++;
            $display("FAIL rem_hold: got %0d required %0d", rem, held_rm);
         end
`endif
         prev_done = 1'b0;
      end
   end

   // Window aligned to the sample edge: num stable for the whole 7-cycle period.
   task automatic run_op(input int v);
      num = 10'(v);
      push_exp(v);
      repeat (7) @(negedge clk);
   endtask

   // Same window, but num is scrambled once it has been sampled.
   task automatic run_op_noisy(input int v);
      num = 10'(v);
      push_exp(v);
      @(negedge clk);
      repeat (6) begin
         num = 10'($urandom_range(0, 1023));
         @(negedge clk);
      end
   endtask

   task automatic edges_to_done(input string name, input int want);
      int n;
      bit seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         @(posedge clk);
         #1;
         n++;
         if (done) seen = 1'b1;
      end
      checks++;
      if (!seen || n != want) begin
         errors++;
         $display("FAIL %s: done after %0d edges (seen=%0d) required %0d", name, n, seen, want);
      end
   endtask

   initial begin
      int wait_n;
      rst = 1'b1;
      num = 10'd9;
      #12;
      checks++;
      if (sqrt !== 5'd0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: sqrt=%0d done=%0d required 0/0", sqrt, done);
      end
      #8;
      rst = 1'b0;
      push_exp(9);
      edges_to_done("first_latency", 7);
      @(negedge clk);
      run_op(9);
      run_op(9);

      run_op(0);
      run_op(1023);
      run_op(15);
      run_op(16);
      run_op(960);
      run_op(961);

      num = 10'd100;
      push_exp(100);
      repeat (3) @(negedge clk);
      num = 10'd400;
      repeat (4) @(negedge clk);
      push_exp(400);
      repeat (7) @(negedge clk);

      num = 10'd500;
      @(posedge clk);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if (sqrt !== 5'd0 || done !== 1'b0) begin
         errors++;
         $display("FAIL mid_calc_reset: sqrt=%0d done=%0d required 0/0", sqrt, done);
      end
      num = 10'd300;
      @(negedge clk);
      #2;
      rst = 1'b0;
      push_exp(300);
      edges_to_done("reset_latency", 7);
      @(negedge clk);

      for (int v = 0; v < 1024; v++) run_op(v);
      for (int i = 0; i < 300; i++) run_op_noisy(int'($urandom_range(0, 1023)));

      wait_n = 0;
      while (sb.size() != 0 && wait_n < 20) begin
         @(negedge clk);
         wait_n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d results outstanding, required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/square_root_floor.md
SQUARE_ROOT_FLOOR -- requirements
Module: square_root_floor

Interface
REQ-001 SHALL have no parameters; operand width fixed at 10 bits, result width fixed at 5 bits.
REQ-002 SHALL provide port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL provide port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port: num  input  10  unsigned operand, sampled by the block (no handshake).
REQ-005 SHALL provide port: sqrt  output  5  registered floor(sqrt(num_sampled)).
REQ-006 SHALL provide port: done  output  1  registered one-cycle pulse coinciding with each sqrt update.
REQ-007 SHALL provide port (only when SQRT_REMAINDER_EN defined): rem  output  6  registered num_sampled - sqrt*sqrt.

Function
REQ-008 SHALL implement a 3-state FSM: IDLE, CALC, DONE; single clock domain, no combinational path from num to any output.
REQ-009 SHALL, in IDLE on a rising edge: latch num into an internal operand register, clear the partial root/remainder registers, load iteration counter with 4, go to CALC.
REQ-010 SHALL, in CALC, perform one restoring digit-by-digit iteration per cycle (bring down next 2 operand bits MSB-first, trial subtract (root<<2)|1, keep the result and shift in root bit 1 if non-negative, else shift in 0), for exactly 5 cycles (counter 4 down to 0), then go to DONE.
REQ-011 SHALL, in DONE on a rising edge: load sqrt with the 5-bit root, assert done for exactly that one cycle, (rem if enabled), go to IDLE.
REQ-012 SHALL recompute continuously: period 7 clock cycles (1 IDLE + 5 CALC + 1 DONE); sqrt reflects the num value sampled 6 edges before its update.
REQ-013 SHALL ignore num changes while in CALC/DONE; new value takes effect at the next IDLE sample.
REQ-014 SHALL hold sqrt (and rem) stable between DONE updates; done SHALL be 0 in all other cycles.
REQ-015 SHALL produce exact floor results over full range 0..1023: 0->0, 1023->31; sqrt never exceeds 31.
REQ-016 SHALL size the internal trial-subtraction/remainder datapath to at least 7 bits so no overflow occurs for any operand.

Reset
REQ-017 SHALL, while rst=1 (asynchronously), force state=IDLE, sqrt=0, done=0, rem=0, and clear operand, partial root, remainder and counter.
REQ-018 SHALL abort any in-progress computation on reset without updating sqrt; first sample occurs at the first rising edge after rst deasserts.

Configuration
REQ-019 SHALL, when macro SQRT_REMAINDER_EN is defined, include output rem and its register, updated in DONE with the final iteration remainder (0..62).
REQ-020 SHALL, when SQRT_REMAINDER_EN is undefined, omit port rem and its logic; all other behaviour identical.

Verification
REQ-021 SHALL verify: rst high 20 ns then low, num=9 held -> sqrt=5'b00011 with done pulse 7th edge after release, stays 3 thereafter.
REQ-022 SHALL verify: num=0 -> sqrt=0; num=1023 -> sqrt=31 (rem=62 with SQRT_REMAINDER_EN).
REQ-023 SHALL verify boundaries: num=15 -> 3, num=16 -> 4, num=960 -> 30, num=961 -> 31.
REQ-024 SHALL verify: num changed from 100 to 400 during CALC -> next update 10, following update 20.
REQ-025 SHALL verify: rst asserted mid-CALC -> sqrt=0, done=0 immediately; after release, correct result 7 edges later.
REQ-026 SHALL verify exhaustively 0..1023 against reference floor-sqrt, checking sqrt at each done pulse.
